// File: rtl/regfile_debug_port_pkg.sv
// Shared definitions for the register file debug port: register count, address width
// and the FSM/mode encodings used by the debug initiator.
package regfile_debug_port_pkg;

  localparam int unsigned REG_COUNT  = 4;
  localparam int unsigned REG_ADDR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_DUMP_RD   = 3'd2,
    ST_DUMP_TX   = 3'd3,
    ST_LOAD_RX   = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  typedef enum logic {
    MODE_DUMP = 1'b0,
    MODE_LOAD = 1'b1
  } mode_e;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug initiator: halts the CPU, then dumps R0..R(N-1) onto a byte stream or loads them from one.
// The load path is built only when REGFILE_DEBUG_LOAD_EN is defined.
module regfile_debug_port
  import regfile_debug_port_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = REG_COUNT,
  parameter int unsigned ADDR_W   = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_dump_req,
  input  logic              i_load_req,
  output logic              o_halt_req,
  input  logic              i_halt_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rf_read_addr,
  input  logic [DATA_W-1:0] i_rf_read_data,
  output logic              o_rf_write_en,
  output logic [ADDR_W-1:0] o_rf_write_addr,
  output logic [DATA_W-1:0] o_rf_write_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_halt_req;
  logic              r_done;
  logic [ADDR_W-1:0] r_rf_read_addr;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              w_last;

`ifdef REGFILE_DEBUG_LOAD_EN
  mode_e             r_mode;
  logic              r_rf_write_en;
  logic [ADDR_W-1:0] r_rf_write_addr;
  logic [DATA_W-1:0] r_rf_write_data;
`else
  logic              w_unused_load;
  assign w_unused_load = ^{i_load_req, i_rx_valid, i_rx_data};
`endif

  // The last-index compare ends every operation, so idx never wraps mid-transfer.
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_halt_req     <= 1'b0;
      r_done         <= 1'b0;
      r_rf_read_addr <= '0;
      r_tx_data      <= '0;
      r_tx_valid     <= 1'b0;
`ifdef REGFILE_DEBUG_LOAD_EN
      r_mode          <= MODE_DUMP;
      r_rf_write_en   <= 1'b0;
      r_rf_write_addr <= '0;
      r_rf_write_data <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef REGFILE_DEBUG_LOAD_EN
      r_rf_write_en <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // Dump has priority when both requests arrive together.
          if (i_dump_req) begin
            r_state    <= ST_HALT_WAIT;
            r_idx      <= '0;
            r_halt_req <= 1'b1;
`ifdef REGFILE_DEBUG_LOAD_EN
            r_mode     <= MODE_DUMP;
          end else if (i_load_req) begin
            r_state    <= ST_HALT_WAIT;
            r_idx      <= '0;
            r_halt_req <= 1'b1;
            r_mode     <= MODE_LOAD;
`endif
          end
        end
        ST_HALT_WAIT: begin
          if (i_halt_ack) begin
`ifdef REGFILE_DEBUG_LOAD_EN
            if (r_mode == MODE_LOAD) begin
              r_state <= ST_LOAD_RX;
            end else begin
              r_state        <= ST_DUMP_RD;
              r_rf_read_addr <= r_idx;
            end
`else
            r_state        <= ST_DUMP_RD;
            r_rf_read_addr <= r_idx;
`endif
          end
        end
        ST_DUMP_RD: begin
          r_tx_data  <= i_rf_read_data;
          r_tx_valid <= 1'b1;
          r_state    <= ST_DUMP_TX;
        end
        ST_DUMP_TX: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            if (w_last) begin
              r_state    <= ST_FINISH;
              r_halt_req <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_idx          <= r_idx + ADDR_W'(1);
              r_rf_read_addr <= r_idx + ADDR_W'(1);
              r_state        <= ST_DUMP_RD;
            end
          end
        end
`ifdef REGFILE_DEBUG_LOAD_EN
        ST_LOAD_RX: begin
          if (i_rx_valid) begin
            r_rf_write_en   <= 1'b1;
            r_rf_write_addr <= r_idx;
            r_rf_write_data <= i_rx_data;
            if (w_last) begin
              r_state    <= ST_FINISH;
              r_halt_req <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end
        end
`endif
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_halt_req     = r_halt_req;
  assign o_done         = r_done;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_rf_read_addr = r_rf_read_addr;
  assign o_tx_data      = r_tx_data;
  assign o_tx_valid     = r_tx_valid;

`ifdef REGFILE_DEBUG_LOAD_EN
  assign o_rx_ready      = (r_state == ST_LOAD_RX);
  assign o_rf_write_en   = r_rf_write_en;
  assign o_rf_write_addr = r_rf_write_addr;
  assign o_rf_write_data = r_rf_write_data;
`else
  assign o_rx_ready      = 1'b0;
  assign o_rf_write_en   = 1'b0;
  assign o_rf_write_addr = '0;
  assign o_rf_write_data = '0;
`endif

endmodule
